present_round_ctrl: RTL and testbench

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

---
 rtl/present_round_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_present_round_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/present_round_ctrl.sv
// present_round_ctrl
//
// Iterative PRESENT-80 block encryptor: one cipher round per clock, with a
// valid/ready handshake on both the job input and the ciphertext output.
// Only one job is in flight at a time. A job is accepted in IDLE, runs
// ROUNDS rounds, whitens with the final round key in FINAL, and then waits
// in DONE until the consumer takes the ciphertext.
//
// Ports
//   clk         system clock, rising-edge active
//   rst         synchronous active-high reset
//   in_valid    plaintext/key valid
//   in_ready    ready to accept a job (IDLE only)
//   plaintext   64-bit block to encrypt
//   key         80-bit user key
//   out_valid   ciphertext valid (held until accepted)
//   out_ready   consumer accepts ciphertext
//   ciphertext  64-bit result, holds its value until the next job finishes
//   busy        high while rounds or final whitening are in progress
//   round_idx   current round counter in ROUND, otherwise 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// ROUND | one PRESENT round per clock, rc = 1..ROUNDS
// FINAL | add last round key, register ciphertext, raise out_valid
// DONE  | ciphertext presented; wait for out_ready

module present_round_ctrl #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy,
    output logic [4:0]  round_idx
);

    localparam logic [4:0] LAST_RC = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [63:0] state_reg;
    logic [63:0] state_reg_d;
    logic [79:0] key_reg;
    logic [79:0] key_reg_d;
    logic [4:0]  rc;
    logic [4:0]  rc_d;
    logic [63:0] ct_d;
    logic        ov_d;

    logic [63:0] round_out;
    logic [79:0] key_next;

    // ------------------------------------------------------------------
    // PRESENT primitives
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  b;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            b = 6'(4 * i);
            y[b +: 4] = sbox(x[b +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays in place.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  src;
        logic [5:0]  dst;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            src    = 6'(i);
            dst    = 6'((16 * i) % 63);
            y[dst] = x[src];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Rotate left by 61, substitute the top nibble, fold the round counter
    // into bits 19:15.
    function automatic logic [79:0] key_update(input logic [79:0] k,
                                               input logic [4:0]  c);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ c;
        return r;
    endfunction

    assign round_out = p_layer(sbox_layer(state_reg ^ key_reg[79:16]));
    assign key_next  = key_update(key_reg, rc);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg;
        key_reg_d   = key_reg;
        rc_d        = rc;
        ct_d        = ciphertext;
        ov_d        = out_valid;
        in_ready    = 1'b0;
        busy        = 1'b0;
        round_idx   = 5'd0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_reg_d = plaintext;
                    key_reg_d   = key;
                    rc_d        = 5'd1;
                    state_d     = S_ROUND;
                end
            end

            S_ROUND: begin
                busy        = 1'b1;
                round_idx   = rc;
                state_reg_d = round_out;
                key_reg_d   = key_next;
                // rc stops at the last round value rather than wrapping
                // past 31 when ROUNDS is at its maximum.
                if (rc == LAST_RC) begin
                    state_d = S_FINAL;
                end else begin
                    rc_d = rc + 5'd1;
                end
            end

            S_FINAL: begin
                busy    = 1'b1;
                ct_d    = state_reg ^ key_reg[79:16];
                ov_d    = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            state_reg  <= '0;
            key_reg    <= '0;
            rc         <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            state_reg  <= state_reg_d;
            key_reg    <= key_reg_d;
            rc         <= rc_d;
            ciphertext <= ct_d;
            out_valid  <= ov_d;
        end
    end

endmodule

// File: tb/tb_present_round_ctrl.sv
// Testbench for present_round_ctrl: directed PRESENT-80 vectors, with
// expected ciphertexts and accept times queued by the driver and consumed
// by an independent output monitor.

module tb_present_round_ctrl;

    localparam int LAT = 32;
    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;
    logic [4:0]  round_idx;

    present_round_ctrl #(.ROUNDS(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job and wait until it is taken. acc_edge is the cycle
    // number of the accepting edge.
    task automatic issue(input logic [63:0] pt, input logic [79:0] k,
                         input logic [63:0] exp, input bit hold,
                         output int acc_edge);
        int n;
        n         = 0;
        acc_edge  = -1;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        exp_q.push_back(exp);
        acc_q.push_back(acc_edge);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    // Output monitor: latency on the rising edge of out_valid, stability
    // while it is held, and value on the handshake.
    logic        ov_prev = 1'b0;
    logic [63:0] ct_prev = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    check("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
                end
            end
            if (out_valid && ov_prev) begin
                check("ct_stable", ciphertext, ct_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_handshake");
                end else begin
                    check("ciphertext", ciphertext, exp_q.pop_front());
                end
            end
        end
        ov_prev = out_valid;
        ct_prev = ciphertext;
    end

    initial begin
        int a1, a2, a3, n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        plaintext = '0;
        key       = '0;
        repeat (3) tick();

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ciphertext", ciphertext, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        rst = 1'b0;
        tick();

        // Zero plaintext, zero key.
        issue(64'd0, 80'd0, 64'h5579C1387B228445, 1'b0, a1);
        check("accept_round_idx", 64'(round_idx), 64'd1);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_in_ready", 64'(in_ready), 64'd0);
        wait_ov();
        check("done_busy", 64'(busy), 64'd0);
        check("done_round_idx", 64'(round_idx), 64'd0);
        repeat (3) tick();

        // All-ones plaintext, zero key; all-zero plaintext, all-ones key.
        issue(ONES64, 80'd0, 64'hA112FFC72F68417B, 1'b0, a1);
        wait_ov();
        repeat (2) tick();
        issue(64'd0, ONES80, 64'hE72C46C0F5945049, 1'b0, a1);
        wait_ov();
        repeat (2) tick();

        // Output stall with all-ones inputs.
        out_ready = 1'b0;
        issue(ONES64, ONES80, 64'h3333DCD3213210D2, 1'b0, a1);
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_ct", ciphertext, 64'h3333DCD3213210D2);
            tick();
        end
        out_ready = 1'b1;
        check("pre_hs_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_ct_hold", ciphertext, 64'h3333DCD3213210D2);
        repeat (2) tick();

        // Reset mid-run discards the job.
        issue(ONES64, ONES80, 64'h3333DCD3213210D2, 1'b0, a1);
        n = 0;
        while (round_idx != 5'd15 && n < 50) begin
            tick();
            n++;
        end
        check("abort_round_idx", 64'(round_idx), 64'd15);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        tick();
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_ct_cleared", ciphertext, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) fail_now("abort_out_valid");
            tick();
        end
        check("abort_idle_out_valid", 64'(out_valid), 64'd0);
        issue(64'd0, 80'd0, 64'h5579C1387B228445, 1'b0, a1);
        wait_ov();
        repeat (2) tick();

        // Inputs and out_ready churn while the job runs.
        issue(ONES64, 80'd0, 64'hA112FFC72F68417B, 1'b0, a1);
        for (int i = 0; i < 20; i++) begin
            in_valid  = ~in_valid;
            out_ready = ~out_ready;
            plaintext = {$urandom, $urandom};
            key       = {16'($urandom), $urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_ov();
        repeat (2) tick();

        // Back-to-back jobs with in_valid and out_ready held high.
        out_ready = 1'b1;
        issue(64'd0, 80'd0, 64'h5579C1387B228445, 1'b1, a1);
        issue(ONES64, 80'd0, 64'hA112FFC72F68417B, 1'b1, a2);
        issue(64'd0, ONES80, 64'hE72C46C0F5945049, 1'b0, a3);
        check("b2b_gap1", 64'(a2 - a1), 64'd34);
        check("b2b_gap2", 64'(a3 - a2), 64'd34);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
